// File: rtl/d_latch.sv
// Level-sensitive D latch, WIDTH bits, identical behaviour in every bit.
// Latency: combinational while en=1 (transparent), holds while en=0.
// Backpressure: none; en is the only qualifier.
// Ports: en (transparency enable), d (data in), q (latched data), qb (~q).
module d_latch #(
    parameter int WIDTH = 1
) (
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] lat_q;

    always_latch begin
        if (en) begin
            lat_q <= d;
        end
    end

    assign q  = lat_q;
    // Complement is derived from the stored value itself, so q and qb
    // can never be skewed against each other.
    assign qb = ~lat_q;

endmodule

// File: rtl/dff.sv
// Rising-edge D flip-flop with synchronous active-high reset, built as a master-slave latch pair.
// Latency: one rising clk edge from d (or rst) to q; qb tracks q with no skew.
// Backpressure: none; a new value is captured on every rising edge.
// Ports: clk (clock), rst (sync reset, active high), d (data in), q (registered data), qb (~q).
module dff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] master_d;
    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] master_qb;

    // Reset is applied in front of the master latch, so it only reaches q
    // through the same rising-edge handoff as ordinary data. An unknown rst
    // falls through to the else branch, i.e. it is treated as inactive.
    always_comb begin
        master_d = d;
        if (rst == 1'b1) begin
            master_d = RESET_VALUE;
        end
    end

    // Master follows its input while clk is low and freezes at the rising
    // edge; the slave opens at that same edge and presents the frozen value.
    d_latch #(
        .WIDTH (WIDTH)
    ) u_master (
        .en (~clk),
        .d  (master_d),
        .q  (master_q),
        .qb (master_qb)
    );

    d_latch #(
        .WIDTH (WIDTH)
    ) u_slave (
        .en (clk),
        .d  (master_q),
        .q  (q),
        .qb (qb)
    );

    // The master's complement output has no downstream consumer; keep it
    // honest so a broken latch shows up right where it happens.
    a_master_complement : assert property (@(posedge clk) master_qb == ~master_q);

endmodule

// File: tb/tb_dff.sv
// Bench for dff: a default 1-bit instance and a 4-bit instance with reset value 1010.
// Clock period 34 ns (17 low / 17 high); inputs driven during the low phase.
// Expected q is computed from the register rule: q = rst ? RESET_VALUE : d at each rising edge.
module tb_dff;

    localparam logic [3:0] RV_B = 4'b1010;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       d_a = 1'b0;
    logic       q_a;
    logic       qb_a;
    logic       rst_b = 1'b0;
    logic [3:0] d_b = 4'h0;
    logic [3:0] q_b;
    logic [3:0] qb_b;

    int checks   = 0;
    int failures = 0;

    // Reference state: what each register must hold after the last rising edge.
    logic       exp_a;
    logic [3:0] exp_b;
    bit         known = 1'b0;

    always #17 clk = ~clk;

    dff u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .d   (d_a),
        .q   (q_a),
        .qb  (qb_a)
    );

    dff #(
        .WIDTH       (4),
        .RESET_VALUE (RV_B)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .d   (d_b),
        .q   (q_b),
        .qb  (qb_b)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_qa"},  {3'b000, q_a},  {3'b000, exp_a});
        check({tag, "_qba"}, {3'b000, qb_a}, {3'b000, ~exp_a});
        check({tag, "_qb4"}, q_b,  exp_b);
        check({tag, "_qbb4"}, qb_b, ~exp_b);
    endtask

    // Entered at falling edge + 1 ns. Drives inputs mid-low-phase, confirms q is
    // unchanged before the rising edge, checks the capture, optionally disturbs
    // d/rst while clk is high, and confirms q survives the high phase and the
    // falling edge. Returns at the next falling edge + 1 ns.
    task automatic step(input logic ra, input logic da, input logic rb,
                        input logic [3:0] db, input bit wiggle);
        #4;
        rst_a = ra;
        d_a   = da;
        rst_b = rb;
        d_b   = db;
        #1;
        if (known) check_state("pre_edge");
        exp_a = ra ? 1'b0 : da;
        exp_b = rb ? RV_B : db;
        @(posedge clk);
        #1;
        known = 1'b1;
        check_state("post_edge");
        if (wiggle) begin
            d_a = ~d_a;
            d_b = ~d_b;
            #3;
            d_a   = 1'($urandom);
            d_b   = 4'($urandom);
            rst_a = 1'($urandom);
            rst_b = 1'($urandom);
            #3;
        end
        #4;
        check_state("mid_high");
        @(negedge clk);
        #1;
        check_state("post_fall");
    endtask

    initial begin
        @(negedge clk);
        #1;
        // Load 0 on A while B is reset to 1010.
        step(1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        // Hold 0 on A; B loads 0110.
        step(1'b0, 1'b0, 1'b0, 4'b0110, 1'b0);
        // Load 1, then hold 1.
        step(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b1111, 1'b0);
        // Hold 1 while d toggles during the high phase; then load 0.
        step(1'b0, 1'b1, 1'b0, 4'b1001, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        // Synchronous reset with d=1, then release.
        step(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        step(1'b1, 1'b1, 1'b1, 4'b0101, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
        // Randomised traffic with occasional reset and high-phase disturbance.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(3) == 0), 1'($urandom),
                 ($urandom_range(3) == 0), 4'($urandom), 1'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
